// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, stall/flush control and a post-flush drop counter.
// Optional performance counters are enabled by defining IFID_PERF_EN.
module if_id_stage #(
  parameter logic [31:0] NOP_INST         = 32'h0000_0013,
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter int unsigned DROP_AFTER_FLUSH = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_snpc,
  input  logic [31:0] in_inst,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_snpc,
  output logic [31:0] out_inst,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [1:0] DROP_LOAD = 2'(DROP_AFTER_FLUSH);

  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_snpc;
  logic [31:0] skid_inst;
  logic [1:0]  drop_cnt;

  logic accept;
  logic dropping;
  logic take;
  logic advance;

  // in_ready depends only on registered state and stall, never on out_ready
  assign in_ready = ~reset & ~skid_valid & ~stall;
  assign accept   = in_valid & in_ready;
  assign dropping = accept & (drop_cnt != 2'd0);
  assign take     = accept & ~dropping;
  assign advance  = ~stall & (~out_valid | out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      out_snpc   <= RESET_PC + 32'd4;
      out_inst   <= NOP_INST;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_snpc  <= '0;
      skid_inst  <= '0;
      drop_cnt   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_inst   <= NOP_INST;
      skid_valid <= 1'b0;
      drop_cnt   <= DROP_LOAD;
    end else begin
      if (dropping)
        drop_cnt <= drop_cnt - 2'd1;
      if (advance) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_pc     <= skid_pc;
          out_snpc   <= skid_snpc;
          out_inst   <= skid_inst;
          skid_valid <= 1'b0;
        end else if (take) begin
          out_valid <= 1'b1;
          out_pc    <= in_pc;
          out_snpc  <= in_snpc;
          out_inst  <= in_inst;
        end else begin
          out_valid <= 1'b0;
          out_inst  <= NOP_INST;
        end
      end else if (take) begin
        // main is full and held by downstream; park the word (skid is empty since in_ready was 1)
        skid_valid <= 1'b1;
        skid_pc    <= in_pc;
        skid_snpc  <= in_snpc;
        skid_inst  <= in_inst;
      end
    end
  end

`ifdef IFID_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!out_valid)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (flush)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt;
  assign perf_flush_cnt  = flush_cnt;
`else
  assign perf_bubble_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif

endmodule
